// File: rtl/clk_gate_ctrl.sv
// Per-channel clock gating controller: an OFF/WAKE/ON/IDLE FSM per channel drives a
// registered gate enable, and a low-transparent latch plus AND produces each gated clock.
module clk_gate_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_CH-1:0]               CH_REQ,
  input  logic [NUM_CH-1:0]               CH_FORCE,
  input  logic                            AUTO_EN,
  input  logic [IDLE_W-1:0]               IDLE_LIMIT,
  output logic [NUM_CH-1:0]               GATED_CLK,
  output logic [NUM_CH-1:0]               CH_READY,
  output logic [$clog2(NUM_CH+1)-1:0]     ACTIVE_CNT
);

  localparam int CNT_W  = $clog2(NUM_CH + 1);
  localparam int WCNT_W = 4;

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd3;

  logic [NUM_CH-1:0] en_d_vec;
  logic [CNT_W-1:0]  active_cnt_q;
  logic [CNT_W-1:0]  active_cnt_d;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [IDLE_W-1:0] icnt_q, icnt_d;
    logic [IDLE_W-1:0] lim_q, lim_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;
    logic              en_lat;
    logic              wake_req;
    logic              stay_on;

    assign wake_req = CH_REQ[gi] | CH_FORCE[gi];
    // Anything that keeps the channel busy, including auto-gating being switched off.
    assign stay_on  = wake_req | ~AUTO_EN;

    always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      icnt_d  = icnt_q;
      lim_d   = lim_q;
      case (state_q)
        S_OFF: begin
          if (wake_req) begin
            state_d = S_WAKE;
            wcnt_d  = '0;
          end
        end
        S_WAKE: begin
          if (wcnt_q == WCNT_W'(WAKE_CYC - 1)) begin
            state_d = S_ON;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
        S_ON: begin
          if (!stay_on) begin
            if (IDLE_LIMIT == '0) begin
              state_d = S_OFF;
            end else begin
              state_d = S_IDLE;
              icnt_d  = '0;
              lim_d   = IDLE_LIMIT;
            end
          end
        end
        S_IDLE: begin
          // Request or AUTO_EN drop wins over a timeout landing on the same cycle.
          if (stay_on) begin
            state_d = S_ON;
          end else if (icnt_q == lim_q - IDLE_W'(1)) begin
            state_d = S_OFF;
          end else begin
            icnt_d = icnt_q + IDLE_W'(1);
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
      en_d    = (state_d != S_OFF);
      ready_d = (state_d == S_ON) || (state_d == S_IDLE);
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= S_OFF;
        wcnt_q  <= '0;
        icnt_q  <= '0;
        lim_q   <= '0;
        en_q    <= 1'b0;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        icnt_q  <= icnt_d;
        lim_q   <= lim_d;
        en_q    <= en_d;
        ready_q <= ready_d;
      end
    end

    // Latch only moves while CLK is low, so the AND below cannot chop a high phase;
    // masking with RST suppresses the pulse on the edge that samples reset.
    always_latch begin
      if (!CLK) begin
        en_lat = en_q & ~RST;
      end
    end

    assign GATED_CLK[gi] = CLK & en_lat;
    assign CH_READY[gi]  = ready_q;
    assign en_d_vec[gi]  = en_d;
  end

  always_comb begin
    active_cnt_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active_cnt_d = active_cnt_d + CNT_W'(en_d_vec[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      active_cnt_q <= '0;
    end else begin
      active_cnt_q <= active_cnt_d;
    end
  end

  assign ACTIVE_CNT = active_cnt_q;

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: CLK_GATE_CTRL

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of independently gated clock channels.
REQ-002 SHALL provide parameter IDLE_W, default 8, width of the idle-timeout counter and of IDLE_LIMIT.
REQ-003 SHALL provide parameter WAKE_CYC, default 2, range 1..15, cycles from wake-up to CH_READY.
REQ-004 SHALL have port CLK  input  1  the single source clock; all logic in this domain.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-006 SHALL have port CH_REQ  input  NUM_CH  per-channel activity request, level.
REQ-007 SHALL have port CH_FORCE  input  NUM_CH  per-channel force-on; overrides auto gating.
REQ-008 SHALL have port AUTO_EN  input  1  1 = idle auto-gating enabled; 0 = woken channels stay on.
REQ-009 SHALL have port IDLE_LIMIT  input  IDLE_W  idle cycles before gating off; sampled on entry to IDLE.
REQ-010 SHALL have port GATED_CLK  output  NUM_CH  per-channel glitch-free gated clock.
REQ-011 SHALL have port CH_READY  output  NUM_CH  1 = channel clock stable and usable.
REQ-012 SHALL have port ACTIVE_CNT  output  $clog2(NUM_CH+1)  number of channels with gate enable set, registered.

Function
REQ-013 SHALL run one FSM per channel: OFF, WAKE, ON, IDLE.
REQ-014 SHALL register a per-channel gate enable EN[i] = 1 in WAKE, ON, IDLE; 0 in OFF.
REQ-015 SHALL form GATED_CLK[i] = CLK AND L[i], L[i] a latch transparent while CLK low, D = EN[i]; no glitch or truncated pulse.
REQ-016 SHALL give first GATED_CLK[i] high pulse at the rising edge one cycle after the edge entering WAKE; last pulse at the edge on which OFF is entered.
REQ-017 OFF -> WAKE when CH_REQ[i] or CH_FORCE[i] = 1; wake counter loaded with 0.
REQ-018 WAKE: counter increments each cycle; -> ON when counter = WAKE_CYC-1; CH_REQ drop in WAKE is ignored (WAKE always completes).
REQ-019 CH_READY[i] SHALL be 1 only in ON and IDLE, registered, asserting WAKE_CYC cycles after WAKE entry.
REQ-020 ON -> IDLE when AUTO_EN=1 and CH_REQ[i]=0 and CH_FORCE[i]=0; idle counter cleared, IDLE_LIMIT captured.
REQ-021 ON -> OFF directly (no IDLE) when the ON->IDLE condition holds and IDLE_LIMIT = 0.
REQ-022 IDLE -> ON when CH_REQ[i] or CH_FORCE[i] = 1, same cycle priority over timeout; no re-wake delay.
REQ-023 IDLE -> OFF when idle counter = captured limit - 1 and no request; counter SHALL NOT wrap.
REQ-024 IDLE with AUTO_EN dropped to 0 SHALL return to ON.
REQ-025 CH_FORCE[i]=1 SHALL hold ON/IDLE->ON regardless of AUTO_EN.
REQ-026 ACTIVE_CNT SHALL equal population count of EN, updated same edge as EN.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels handled in the same cycle.

Reset
REQ-028 RST=1 SHALL force all FSMs to OFF, EN=0, counters=0, CH_READY=0, ACTIVE_CNT=0 on the next CLK edge.
REQ-029 GATED_CLK SHALL be low from the first CLK low phase after reset is sampled; no pulses while RST=1.
REQ-030 RST mid-WAKE or mid-IDLE SHALL abort the sequence; no partial READY after release.
REQ-031 After RST release, a request held high SHALL restart from OFF->WAKE on the first non-reset edge.

Verification (NUM_CH=4, WAKE_CYC=2, IDLE_W=8)
REQ-032 Reset: RST=1 for 3 cycles with CH_REQ=4'hF -> GATED_CLK=0, CH_READY=0, ACTIVE_CNT=0 throughout.
REQ-033 Wake: CH_REQ[0] 0->1 at edge t -> EN[0]=1 at t, first GATED_CLK[0] pulse at t+1, CH_READY[0]=1 at t+2, ACTIVE_CNT=1.
REQ-034 Timeout: AUTO_EN=1, IDLE_LIMIT=3, CH_REQ[1] drops while ON -> IDLE, OFF after 3 cycles, CH_READY[1]=0, no glitch on GATED_CLK[1].
REQ-035 Rescue: IDLE_LIMIT=3, CH_REQ[2] reasserted in 2nd idle cycle -> back to ON next edge, CH_READY[2] stays 1, no gap in GATED_CLK[2].
REQ-036 Force/limits: CH_FORCE[3]=1 with AUTO_EN=1 -> channel 3 never leaves ON; IDLE_LIMIT=0 on channel 0 -> ON->OFF in one cycle.
REQ-037 Mid-op reset: RST asserted during WAKE of channels 0..3 -> all OFF next edge, ACTIVE_CNT=0, CH_READY never asserted.
